// File: rtl/data_sram_resp.sv
// Data-side SRAM responder: word array with programmable access latency and a memory-stage stall.
// Optional out-of-range detection on the upper address bits is enabled by defining DSRAM_RANGE_CHK_EN.
module data_sram_resp #(
  parameter int ADDR_W  = 10,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_en,
  input  logic        mem_wen,
  input  logic [3:0]  mem_sel,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  output logic [31:0] mem_rdata,
  output logic        mem_stall,
  output logic        mem_err
);

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_e;

  localparam logic [3:0] LAT_LAST = 4'(LATENCY - 1);

  state_e              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic                wen_q, wen_d;
  logic [3:0]          sel_q, sel_d;
  logic [ADDR_W-1:0]   idx_q, idx_d;
  logic                oor_q, oor_d;
  logic [31:0]         wdata_q, wdata_d;
  logic [31:0]         rdata_q, rdata_d;
  logic [31:0]         mem_q [0:(1<<ADDR_W)-1];

  logic [ADDR_W-1:0]   in_idx;
  logic                oor_in;
  logic                unused_addr;

  assign in_idx = mem_addr[ADDR_W+1:2];

`ifdef DSRAM_RANGE_CHK_EN
  assign oor_in      = |mem_addr[31:ADDR_W+2];
  assign unused_addr = ^mem_addr[1:0];
  assign mem_err     = (state_q == DONE) & oor_q;
`else
  assign oor_in      = 1'b0;
  assign unused_addr = ^{mem_addr[31:ADDR_W+2], mem_addr[1:0]};
  assign mem_err     = 1'b0;
`endif

  // Gated by rst so a core holding mem_en during reset is never stalled.
  assign mem_stall = rst & (((state_q == IDLE) & mem_en) | (state_q == BUSY));
  assign mem_rdata = rdata_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wen_d   = wen_q;
    sel_d   = sel_q;
    idx_d   = idx_q;
    oor_d   = oor_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: begin
        if (mem_en) begin
          wen_d   = mem_wen;
          sel_d   = mem_sel;
          idx_d   = in_idx;
          oor_d   = oor_in;
          wdata_d = mem_wdata;
          cnt_d   = 4'd1;
          state_d = (LATENCY == 1) ? DONE : BUSY;
        end
      end
      BUSY: begin
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == LAT_LAST) state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
        cnt_d   = 4'd0;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 4'd0;
      end
    endcase
    // The *_d request fields already hold the captured copy on the edge entering DONE.
    if ((state_d == DONE) && (state_q != DONE) && !wen_d) begin
      rdata_d = oor_d ? 32'h0 : mem_q[idx_d];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      wen_q   <= 1'b0;
      sel_q   <= 4'd0;
      idx_q   <= '0;
      oor_q   <= 1'b0;
      wdata_q <= 32'h0;
      rdata_q <= 32'h0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wen_q   <= wen_d;
      sel_q   <= sel_d;
      idx_q   <= idx_d;
      oor_q   <= oor_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  // Array is not reset; a write commits on the edge leaving DONE unless reset discards it.
  always_ff @(posedge clk) begin
    if (rst && (state_q == DONE) && wen_q && !oor_q) begin
      for (int i = 0; i < 4; i++) begin
        if (sel_q[i]) mem_q[idx_q][8*i +: 8] <= wdata_q[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_data_sram_resp.sv
// Bench for data_sram_resp: one instance at LATENCY=2 and one at LATENCY=1, checked against a word-array model.
module tb_data_sram_resp;

  localparam int AW = 10;

  logic        clk = 1'b0;
  logic        rst;
  logic        en    [2];
  logic        wen   [2];
  logic [3:0]  sel   [2];
  logic [31:0] addr  [2];
  logic [31:0] wdata [2];
  logic [31:0] rdata [2];
  logic        stall [2];
  logic        err   [2];

  int          lat [2] = '{2, 1};
  int          checks = 0;
  int          errors = 0;
  logic [31:0] model_mem [2][0:(1<<AW)-1];
  logic [31:0] last_rd [2];
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  data_sram_resp #(.ADDR_W(AW), .LATENCY(2)) u_lat2 (
    .clk(clk), .rst(rst), .mem_en(en[0]), .mem_wen(wen[0]), .mem_sel(sel[0]),
    .mem_addr(addr[0]), .mem_wdata(wdata[0]), .mem_rdata(rdata[0]),
    .mem_stall(stall[0]), .mem_err(err[0])
  );

  data_sram_resp #(.ADDR_W(AW), .LATENCY(1)) u_lat1 (
    .clk(clk), .rst(rst), .mem_en(en[1]), .mem_wen(wen[1]), .mem_sel(sel[1]),
    .mem_addr(addr[1]), .mem_wdata(wdata[1]), .mem_rdata(rdata[1]),
    .mem_stall(stall[1]), .mem_err(err[1])
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic is_oor(input logic [31:0] a);
`ifdef DSRAM_RANGE_CHK_EN
    return (a >> (AW + 2)) != 32'h0;
`else
    return 1'b0;
`endif
  endfunction

  // Called at a negedge with the DUT idle; returns at the negedge after the response cycle.
  task automatic access(input int k, input logic w, input logic [3:0] s,
                        input logic [31:0] a, input logic [31:0] d, input logic keep);
    logic [AW-1:0] idx;
    logic          oor;
    idx = a[AW+1:2];
    oor = is_oor(a);
    en[k] = 1'b1; wen[k] = w; sel[k] = s; addr[k] = a; wdata[k] = d;
    if (!w) exp_q.push_back(oor ? 32'h0 : model_mem[k][idx]);
    #1;
    for (int c = 0; c < lat[k]; c++) begin
      check($sformatf("stall_req%0d_c%0d", k, c), 32'(stall[k]), 32'd1);
      @(negedge clk);
    end
    check($sformatf("stall_done%0d", k), 32'(stall[k]), 32'd0);
    check($sformatf("err_done%0d", k), 32'(err[k]), 32'(oor));
    if (!w) last_rd[k] = exp_q.pop_front();
    check($sformatf("rdata_done%0d_a%h", k, a), rdata[k], last_rd[k]);
    if (w && !oor) begin
      for (int i = 0; i < 4; i++) begin
        if (s[i]) model_mem[k][idx][8*i +: 8] = d[8*i +: 8];
      end
    end
    if (!keep) en[k] = 1'b0;
    @(negedge clk);
    if (!keep) begin
      check($sformatf("stall_idle%0d", k), 32'(stall[k]), 32'd0);
      check($sformatf("err_idle%0d", k), 32'(err[k]), 32'd0);
    end
  endtask

  task automatic hold_reset(input int cycles);
    rst = 1'b0;
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        check($sformatf("rst_stall%0d", k), 32'(stall[k]), 32'd0);
        check($sformatf("rst_rdata%0d", k), rdata[k], 32'h0);
        check($sformatf("rst_err%0d", k), 32'(err[k]), 32'd0);
      end
    end
    last_rd[0] = 32'h0;
    last_rd[1] = 32'h0;
    rst = 1'b1;
    for (int k = 0; k < 2; k++) en[k] = 1'b0;
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      en[k] = 1'b1; wen[k] = 1'b1; sel[k] = 4'hF; addr[k] = 32'h0; wdata[k] = 32'hFFFF_FFFF;
      last_rd[k] = 32'h0;
    end
    rst = 1'b0;
    @(negedge clk);
    hold_reset(2);
    @(negedge clk);

    // Fill the words the bench touches so every read has a defined model value.
    for (int i = 0; i < 16; i++) begin
      access(0, 1'b1, 4'hF, 32'(i * 4), $urandom(), 1'b0);
      access(1, 1'b1, 4'hF, 32'(i * 4), $urandom(), 1'b0);
    end
    access(0, 1'b1, 4'hF, 32'h0, 32'h0BAD_CAFE, 1'b0);

    // Reset with a write presented must not touch the array.
    en[0] = 1'b1; wen[0] = 1'b1; sel[0] = 4'hF; addr[0] = 32'h0; wdata[0] = 32'h1111_1111;
    hold_reset(2);
    @(negedge clk);
    access(0, 1'b0, 4'hF, 32'h0, 32'h0, 1'b0);
    check("rst_prior_word0", rdata[0], 32'h0BAD_CAFE);

    access(0, 1'b1, 4'hF, 32'h10, 32'hDEAD_BEEF, 1'b0);
    access(0, 1'b0, 4'hF, 32'h10, 32'h0, 1'b0);
    check("full_write_read", rdata[0], 32'hDEAD_BEEF);
    access(0, 1'b1, 4'b0100, 32'h10, 32'h00AA_0000, 1'b0);
    check("write_keeps_rdata", rdata[0], 32'hDEAD_BEEF);
    access(0, 1'b0, 4'hF, 32'h10, 32'h0, 1'b0);
    check("partial_write", rdata[0], 32'hDEAA_BEEF);
    access(0, 1'b1, 4'b0000, 32'h10, 32'hFFFF_FFFF, 1'b0);
    access(0, 1'b0, 4'hF, 32'h10, 32'h0, 1'b0);
    check("sel_zero_write", rdata[0], 32'hDEAA_BEEF);

    // LATENCY=1 back-to-back reads with mem_en held.
    access(1, 1'b1, 4'hF, 32'h10, 32'hAAAA_5555, 1'b0);
    access(1, 1'b1, 4'hF, 32'h14, 32'h1234_ABCD, 1'b0);
    access(1, 1'b0, 4'hF, 32'h10, 32'h0, 1'b1);
    access(1, 1'b0, 4'hF, 32'h14, 32'h0, 1'b0);
    check("b2b_second_read", rdata[1], 32'h1234_ABCD);

    // Reset during BUSY discards the pending write.
    access(0, 1'b1, 4'hF, 32'h20, 32'hCAFE_F00D, 1'b0);
    en[0] = 1'b1; wen[0] = 1'b1; sel[0] = 4'hF; addr[0] = 32'h20; wdata[0] = 32'h1234_5678;
    #1;
    check("midrst_stall_accept", 32'(stall[0]), 32'd1);
    @(negedge clk);
    check("midrst_stall_busy", 32'(stall[0]), 32'd1);
    hold_reset(1);
    @(negedge clk);
    check("midrst_idle_stall", 32'(stall[0]), 32'd0);
    access(0, 1'b0, 4'hF, 32'h20, 32'h0, 1'b0);
    check("midrst_old_value", rdata[0], 32'hCAFE_F00D);

    // Upper address bits set: out of range with the check enabled, aliasing otherwise.
    access(0, 1'b0, 4'hF, 32'h8000_0010, 32'h0, 1'b0);
    access(0, 1'b1, 4'hF, 32'h8000_0010, 32'h5A5A_5A5A, 1'b0);
    access(0, 1'b0, 4'hF, 32'h10, 32'h0, 1'b0);

    for (int n = 0; n < 60; n++) begin
      int          k;
      logic [31:0] a;
      k = $urandom_range(0, 1);
      a = 32'($urandom_range(0, 15) * 4 + $urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) a = a | ($urandom() << 12);
      access(k, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), a, $urandom(), 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
